// File: rtl/flag_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : flag_pkg                                                        |
// | Brief    : Shared types for the flag condition resolver: condition codes,  |
// |            status-flag layout and flag width.                              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package flag_pkg;

    localparam int FLAGS_W = 4;

    typedef enum logic [3:0] {
        EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
        MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
        HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
        GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
    } cond_e;

    typedef struct packed {
        logic o;
        logic s;
        logic z;
        logic c;
    } flags_t;

endpackage
`default_nettype wire

// File: rtl/flag_cond_eval.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : flag_cond_eval                                                  |
// | Brief    : Combinational evaluation of a 4-bit condition code against a    |
// |            set of status flags.                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module flag_cond_eval
    import flag_pkg::*;
(
    input  flags_t i_flags,
    input  cond_e  i_cond,
    output logic   o_taken
);

    logic w_ge;

    assign w_ge = (i_flags.s == i_flags.o);

    always_comb begin
        o_taken = 1'b0;
        case (i_cond)
            EQ:      o_taken = i_flags.z;
            NE:      o_taken = !i_flags.z;
            CS:      o_taken = i_flags.c;
            CC:      o_taken = !i_flags.c;
            MI:      o_taken = i_flags.s;
            PL:      o_taken = !i_flags.s;
            VS:      o_taken = i_flags.o;
            VC:      o_taken = !i_flags.o;
            HI:      o_taken = i_flags.c & !i_flags.z;
            LS:      o_taken = !i_flags.c | i_flags.z;
            GE:      o_taken = w_ge;
            LT:      o_taken = !w_ge;
            GT:      o_taken = !i_flags.z & w_ge;
            LE:      o_taken = i_flags.z | !w_ge;
            AL:      o_taken = 1'b1;
            NV:      o_taken = 1'b0;
            default: o_taken = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/flag_cond_resolver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : flag_cond_resolver                                              |
// | Brief    : Latches ALU C/Z/S/O flags into a status register, resolves      |
// |            branch condition codes over a 1-stage valid/ready pipe and      |
// |            keeps a save/restore stack of flag snapshots.                   |
// |            Optional: FLAG_FWD_EN forwards same-cycle flag updates into     |
// |            evaluation instead of stalling requests.                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module flag_cond_resolver
    import flag_pkg::*;
#(
    parameter int STACK_DEPTH = 4,
    parameter int TAG_W       = 4
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               flag_we,
    input  logic               c_in,
    input  logic               z_in,
    input  logic               s_in,
    input  logic               o_in,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [3:0]         req_cond,
    input  logic [TAG_W-1:0]   req_tag,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_taken,
    output logic [TAG_W-1:0]   res_tag,
    input  logic               push,
    input  logic               pop,
    output logic [FLAGS_W-1:0] flags_out,
    output logic               stk_err
);

    localparam int                IDX_W       = $clog2(STACK_DEPTH);
    localparam int                CNT_W       = IDX_W + 1;
    localparam logic [CNT_W-1:0]  c_CNT_FULL  = CNT_W'(STACK_DEPTH);
    localparam logic [CNT_W-1:0]  c_CNT_EMPTY = '0;
    localparam logic [IDX_W-1:0]  c_IDX_ONE   = IDX_W'(1);
    localparam logic [0:0]        c_ST_EMPTY  = 1'b0;
    localparam logic [0:0]        c_ST_FULL   = 1'b1;

    flags_t           r_flags;
    flags_t           r_stack [STACK_DEPTH];
    logic [CNT_W-1:0] r_count;
    logic             r_stk_err;
    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic             r_res_taken;
    logic [TAG_W-1:0] r_res_tag;

    flags_t           w_flags_in;
    flags_t           w_stack_top;
    flags_t           w_eval_flags;
    logic [IDX_W-1:0] w_top_idx;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic             w_stk_fault;
    logic             w_accept;
    logic             w_taken;

    assign w_flags_in  = {o_in, s_in, z_in, c_in};
    // Low index bits wrap correctly even when the stack is full.
    assign w_top_idx   = r_count[IDX_W-1:0] - c_IDX_ONE;
    assign w_stack_top = r_stack[w_top_idx];

    assign w_push_ok   = push & !pop & (r_count != c_CNT_FULL);
    assign w_pop_ok    = pop & !push & (r_count != c_CNT_EMPTY);
    assign w_stk_fault = (push & pop)
                       | (push & (r_count == c_CNT_FULL))
                       | (pop  & (r_count == c_CNT_EMPTY));

`ifdef FLAG_FWD_EN
    assign req_ready    = (r_state == c_ST_EMPTY) | res_ready;
    assign w_eval_flags = flag_we  ? w_flags_in  :
                          w_pop_ok ? w_stack_top : r_flags;
`else
    // Requests stall for a cycle while the status register is being rewritten.
    assign req_ready    = ((r_state == c_ST_EMPTY) | res_ready) & !flag_we & !pop;
    assign w_eval_flags = r_flags;
`endif

    assign w_accept = req_valid & req_ready;

    flag_cond_eval u_eval (
        .i_flags (w_eval_flags),
        .i_cond  (cond_e'(req_cond)),
        .o_taken (w_taken)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags   <= '0;
            r_count   <= c_CNT_EMPTY;
            r_stk_err <= 1'b0;
        end else begin
            if (flag_we)
                r_flags <= w_flags_in;
            else if (w_pop_ok)
                r_flags <= w_stack_top;

            if (w_push_ok)
                r_count <= r_count + CNT_W'(1);
            else if (w_pop_ok)
                r_count <= r_count - CNT_W'(1);

            if (w_stk_fault)
                r_stk_err <= 1'b1;
        end
    end

    // Snapshot storage has no reset; the count alone defines what is live.
    always_ff @(posedge clk) begin
        if (!rst && w_push_ok)
            r_stack[r_count[IDX_W-1:0]] <= r_flags;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= c_ST_EMPTY;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_EMPTY: if (w_accept)               w_state_nxt = c_ST_FULL;
            c_ST_FULL:  if (!w_accept && res_ready) w_state_nxt = c_ST_EMPTY;
            default:                                w_state_nxt = c_ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_taken <= 1'b0;
            r_res_tag   <= '0;
        end else if (w_accept) begin
            r_res_taken <= w_taken;
            r_res_tag   <= req_tag;
        end
    end

    assign res_valid = (r_state == c_ST_FULL);
    assign res_taken = r_res_taken;
    assign res_tag   = r_res_tag;
    assign flags_out = r_flags;
    assign stk_err   = r_stk_err;

endmodule
`default_nettype wire

// File: tb/tb_flag_cond_resolver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_flag_cond_resolver                                           |
// | Brief    : Scoreboard bench for flag_cond_resolver with directed vectors.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_flag_cond_resolver;
    import flag_pkg::*;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst, flag_we, c_in, z_in, s_in, o_in;
    logic             req_valid, req_ready, res_valid, res_ready, res_taken;
    logic [3:0]       req_cond;
    logic [TAG_W-1:0] req_tag, res_tag;
    logic             push, pop, stk_err;
    logic [3:0]       flags_out;

    typedef struct packed {
        logic             taken;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    flag_cond_resolver #(.STACK_DEPTH(4), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flag_we(flag_we),
        .c_in(c_in), .z_in(z_in), .s_in(s_in), .o_in(o_in),
        .req_valid(req_valid), .req_ready(req_ready), .req_cond(req_cond), .req_tag(req_tag),
        .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken), .res_tag(res_tag),
        .push(push), .pop(pop), .flags_out(flags_out), .stk_err(stk_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every completed result transfer is matched against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got tag %0h with no request pending", res_tag);
            end else begin
                e = sb_q.pop_front();
                chk($sformatf("result_taken_tag%0h", e.tag), {31'd0, res_taken}, {31'd0, e.taken});
                chk("result_tag", {28'd0, res_tag}, {28'd0, e.tag});
            end
        end
    end

    task automatic issue(input logic [3:0] c, input logic [TAG_W-1:0] t, input logic e);
        int waited = 0;
        req_valid = 1'b1;
        req_cond  = c;
        req_tag   = t;
        @(negedge clk);
        while (!req_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_accept_timeout: req_ready=0 expected 1 within 20 cycles");
        end else begin
            sb_q.push_back('{taken: e, tag: t});
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic set_flags(input logic [3:0] f);
        flag_we = 1'b1;
        {o_in, s_in, z_in, c_in} = f;
        @(posedge clk); #1;
        flag_we = 1'b0;
        chk("flags_load", {28'd0, flags_out}, {28'd0, f});
    endtask

    task automatic do_stack(input logic p_push, input logic p_pop);
        push = p_push;
        pop  = p_pop;
        @(posedge clk); #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while (sb_q.size() != 0 && waited < 20) begin
            waited++;
            @(posedge clk); #1;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // NE request in the same cycle the register is rewritten to z=1 (by flag_we or pop).
    task automatic same_cycle(input logic use_pop, input logic [TAG_W-1:0] t);
        int waited = 0;
        flag_we = !use_pop;
        pop     = use_pop;
        {o_in, s_in, z_in, c_in} = 4'b0010;
        req_valid = 1'b1;
        req_cond  = NE;
        req_tag   = t;
        @(negedge clk);
`ifdef FLAG_FWD_EN
        chk("fwd_req_ready", {31'd0, req_ready}, 32'd1);
`else
        chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
`endif
        if (req_ready) begin
            sb_q.push_back('{taken: 1'b0, tag: t});
            @(posedge clk); #1;
            flag_we = 1'b0;
            pop     = 1'b0;
        end else begin
            @(posedge clk); #1;
            flag_we = 1'b0;
            pop     = 1'b0;
            @(negedge clk);
            while (!req_ready && waited < 20) begin
                waited++;
                @(negedge clk);
            end
            chk("stall_release_ready", {31'd0, req_ready}, 32'd1);
            if (req_ready) sb_q.push_back('{taken: 1'b0, tag: t});
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        chk("same_cycle_flags", {28'd0, flags_out}, 32'h2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        rst = 1'b1; flag_we = 1'b0; {o_in, s_in, z_in, c_in} = 4'b0000;
        req_valid = 1'b0; req_cond = 4'h0; req_tag = '0;
        res_ready = 1'b1; push = 1'b0; pop = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("reset_flags_out", {28'd0, flags_out}, 32'h0);
        chk("reset_res_valid", {31'd0, res_valid}, 32'd0);
        chk("reset_res_taken", {31'd0, res_taken}, 32'd0);
        chk("reset_res_tag",   {28'd0, res_tag},   32'd0);
        chk("reset_stk_err",   {31'd0, stk_err},   32'd0);
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        issue(EQ, 4'hA, 1'b0);
        drain();

        // z=1, four requests back to back
        set_flags(4'b0010);
        start = cyc;
        issue(EQ, 4'h1, 1'b1);
        issue(NE, 4'h2, 1'b0);
        issue(AL, 4'h3, 1'b1);
        issue(NV, 4'h4, 1'b0);
        chk("b2b_cycles", cyc - start, 32'd4);
        drain();

        set_flags(4'b0100);
        issue(GE, 4'h5, 1'b0); issue(LT, 4'h6, 1'b1);
        issue(GT, 4'h7, 1'b0); issue(LE, 4'h8, 1'b1);
        set_flags(4'b0001);
        issue(HI, 4'h9, 1'b1); issue(LS, 4'hA, 1'b0);
        issue(CS, 4'hB, 1'b1); issue(CC, 4'hC, 1'b0);
        set_flags(4'b1010);
        issue(VS, 4'h1, 1'b1); issue(VC, 4'h2, 1'b0);
        issue(MI, 4'h3, 1'b0); issue(PL, 4'h4, 1'b1);
        issue(GT, 4'h5, 1'b0); issue(LE, 4'h6, 1'b1);
        set_flags(4'b1100);
        issue(GE, 4'h7, 1'b1); issue(GT, 4'h8, 1'b1);
        drain();

        // Backpressure: result must hold while a second request waits
        res_ready = 1'b0;
        issue(AL, 4'h5, 1'b1);
        req_valid = 1'b1; req_cond = NV; req_tag = 4'h6;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_res_valid", {31'd0, res_valid}, 32'd1);
            chk("hold_res_taken", {31'd0, res_taken}, 32'd1);
            chk("hold_res_tag",   {28'd0, res_tag},   32'h5);
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("release_req_ready", {31'd0, req_ready}, 32'd1);
        if (req_ready) sb_q.push_back('{taken: 1'b0, tag: 4'h6});
        @(posedge clk); #1;
        req_valid = 1'b0;
        drain();

        // Stack: fill, overflow, unwind, underflow
        for (int i = 0; i < 4; i++) begin
            set_flags(4'(1 << i));
            do_stack(1'b1, 1'b0);
        end
        chk("stack_full_no_err", {31'd0, stk_err}, 32'd0);
        set_flags(4'h3);
        do_stack(1'b1, 1'b0);
        chk("overflow_err", {31'd0, stk_err}, 32'd1);
        set_flags(4'hF);
        for (int i = 3; i >= 0; i--) begin
            do_stack(1'b0, 1'b1);
            chk($sformatf("pop_%0d", 3 - i), {28'd0, flags_out}, 32'(1 << i));
        end
        do_stack(1'b0, 1'b1);
        chk("underflow_flags", {28'd0, flags_out}, 32'h1);
        chk("err_sticky", {31'd0, stk_err}, 32'd1);

        // Reset drops a pending result and empties the stack
        res_ready = 1'b0;
        issue(AL, 4'h7, 1'b1);
        do_reset();
        sb_q.delete();
        @(negedge clk);
        chk("midrst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("midrst_stk_err",   {31'd0, stk_err},   32'd0);
        chk("midrst_flags",     {28'd0, flags_out}, 32'h0);
        @(posedge clk); #1;
        res_ready = 1'b1;
        set_flags(4'h5);
        do_stack(1'b0, 1'b1);
        chk("empty_pop_flags", {28'd0, flags_out}, 32'h5);
        chk("empty_pop_err", {31'd0, stk_err}, 32'd1);

        // Simultaneous push and pop are both ignored
        do_reset();
        set_flags(4'h6);
        do_stack(1'b1, 1'b0);
        chk("single_push_err", {31'd0, stk_err}, 32'd0);
        set_flags(4'h9);
        do_stack(1'b1, 1'b1);
        chk("pushpop_err", {31'd0, stk_err}, 32'd1);
        chk("pushpop_flags", {28'd0, flags_out}, 32'h9);
        do_stack(1'b0, 1'b1);
        chk("pushpop_then_pop", {28'd0, flags_out}, 32'h6);

        // Same-cycle flag update and stack restore against a request
        set_flags(4'h0);
        same_cycle(1'b0, 4'hC);
        drain();
        set_flags(4'h0);
        do_stack(1'b1, 1'b0);
        set_flags(4'h2);
        do_stack(1'b1, 1'b0);
        set_flags(4'h0);
        same_cycle(1'b1, 4'hD);
        drain();

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
